// File: rtl/mux_display.sv
// Time-multiplexed driver for a 4-digit, 7-segment display sharing one segment bus.
// A prescaler advances the digit select; enables and segments are registered one cycle behind it.
module mux_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] D0,
  input  logic [6:0] D1,
  input  logic [6:0] D2,
  input  logic [6:0] D3,
  output logic [3:0] ED_out,
  output logic [6:0] D_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       ed_q,  ed_d;
  logic [6:0]       seg_q, seg_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end

    // Outputs follow the pre-edge select, so they trail sel_q by one cycle.
    ed_d  = ~(4'b0001 << sel_q);
    seg_d = D0;
    case (sel_q)
      2'd0:    seg_d = D0;
      2'd1:    seg_d = D1;
      2'd2:    seg_d = D2;
      default: seg_d = D3;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= '0;
      ed_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      ed_q  <= ed_d;
      seg_q <= seg_d;
    end
  end

  assign ED_out = ed_q;
  assign D_out  = seg_q;

endmodule

// File: tb/tb_mux_display.sv
// Directed and table-driven checks of mux_display at REFRESH_DIV = 4, 1 and 3.
// All instances share clock, reset and digit inputs; each phase checks the instance it targets.
module tb_mux_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] d0, d1, d2, d3;
  logic [3:0] ed4, ed1, ed3;
  logic [6:0] seg4, seg1, seg3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mux_display #(.REFRESH_DIV(4)) u_div4 (
    .clock(clock), .reset(reset), .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .ED_out(ed4), .D_out(seg4)
  );
  mux_display #(.REFRESH_DIV(1)) u_div1 (
    .clock(clock), .reset(reset), .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .ED_out(ed1), .D_out(seg1)
  );
  mux_display #(.REFRESH_DIV(3)) u_div3 (
    .clock(clock), .reset(reset), .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .ED_out(ed3), .D_out(seg3)
  );

  typedef struct {
    int         first;
    int         last;
    logic [3:0] ed;
    logic [6:0] seg;
  } row_t;

  localparam logic [6:0] P0 = 7'b1111000;
  localparam logic [6:0] P1 = 7'b0001111;
  localparam logic [6:0] P2 = 7'b0011100;
  localparam logic [6:0] P3 = 7'b1100011;

  logic [3:0] ed_of [4];
  row_t       scan_tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act[6:0], exp[6:0], $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic set_default_inputs();
    d0 = P0; d1 = P1; d2 = P2; d3 = P3;
  endtask

  initial begin
    logic [6:0] dnow [4];
    int         digit;
    int         km;

    ed_of[0] = 4'b1110; ed_of[1] = 4'b1101; ed_of[2] = 4'b1011; ed_of[3] = 4'b0111;
    scan_tbl[0] = '{first: 1,  last: 4,  ed: 4'b1110, seg: P0};
    scan_tbl[1] = '{first: 5,  last: 8,  ed: 4'b1101, seg: P1};
    scan_tbl[2] = '{first: 9,  last: 12, ed: 4'b1011, seg: P2};
    scan_tbl[3] = '{first: 13, last: 16, ed: 4'b0111, seg: P3};

    set_default_inputs();

    // Reset held high: blank outputs every cycle.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_ed",  32'(ed4),  32'(4'b1111));
      check("reset_seg", 32'(seg4), 32'(7'b1111111));
      check("reset_ed_div1", 32'(ed1), 32'(4'b1111));
    end

    // Full scan at REFRESH_DIV=4 over two frames, driven from the table.
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      km = ((k - 1) % 16) + 1;
      for (int r = 0; r < 4; r++) begin
        if (km >= scan_tbl[r].first && km <= scan_tbl[r].last) begin
          check("scan_ed",  32'(ed4),  32'(scan_tbl[r].ed));
          check("scan_seg", 32'(seg4), 32'(scan_tbl[r].seg));
        end
      end
    end

    // Changing the active digit's pattern shows up on the next edge.
    do_reset(2);
    tick(); tick();
    d0 = 7'b0000001;
    tick();
    check("chg_seg_c3", 32'(seg4), 32'(7'b0000001));
    check("chg_ed_c3",  32'(ed4),  32'(4'b1110));
    tick();
    check("chg_seg_c4", 32'(seg4), 32'(7'b0000001));
    tick();
    check("chg_ed_c5",  32'(ed4),  32'(4'b1101));
    check("chg_seg_c5", 32'(seg4), 32'(P1));
    set_default_inputs();

    // One-cycle reset pulse in the middle of digit 2 restarts the scan.
    do_reset(2);
    repeat (10) tick();
    check("mid_ed_c10",  32'(ed4),  32'(4'b1011));
    check("mid_seg_c10", 32'(seg4), 32'(P2));
    reset = 1'b1;
    tick();
    check("mid_rst_ed",  32'(ed4),  32'(4'b1111));
    check("mid_rst_seg", 32'(seg4), 32'(7'b1111111));
    reset = 1'b0;
    tick();
    check("restart_ed",  32'(ed4),  32'(4'b1110));
    check("restart_seg", 32'(seg4), 32'(P0));
    repeat (3) tick();
    check("restart_ed_c4", 32'(ed4), 32'(4'b1110));
    tick();
    check("restart_ed_c5",  32'(ed4),  32'(4'b1101));
    check("restart_seg_c5", 32'(seg4), 32'(P1));

    // REFRESH_DIV=1 advances the digit every cycle.
    do_reset(2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      digit = (k - 1) % 4;
      check("div1_ed", 32'(ed1), 32'(ed_of[digit]));
      case (digit)
        0: check("div1_seg", 32'(seg1), 32'(P0));
        1: check("div1_seg", 32'(seg1), 32'(P1));
        2: check("div1_seg", 32'(seg1), 32'(P2));
        default: check("div1_seg", 32'(seg1), 32'(P3));
      endcase
    end

    // Random patterns at REFRESH_DIV=3: segments track the inputs sampled at the edge.
    do_reset(2);
    for (int k = 1; k <= 1000; k++) begin
      for (int j = 0; j < 4; j++) dnow[j] = 7'($urandom_range(0, 127));
      d0 = dnow[0]; d1 = dnow[1]; d2 = dnow[2]; d3 = dnow[3];
      tick();
      digit = ((k - 1) / 3) % 4;
      check("rand_ed",  32'(ed3),  32'(ed_of[digit]));
      check("rand_seg", 32'(seg3), 32'(dnow[digit]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
